bus_timer: RTL and testbench
============================

Name: bus_timer

Overview:
- Programmable down-counting timer device. Sits directly downstream of the multi-cycle CPU core on its processor bus: PrAddr/PrDOut/Wen come in, PrDIn goes out.
- Its interrupt output drives one bit of the core's HWInt vector, for CP0 interrupt testing.
- Three word registers: CTRL, PRESET, COUNT.
- Two modes: one-shot sticky interrupt, and auto-reload periodic pulse.

Parameters:
- DATA_W, 32, width of bus data and of PRESET/COUNT.
- CTRL_W, 4, implemented CTRL bits; upper bits read as 0.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  asynchronous, active-low reset.
- Addr  input  2  word offset within the device: PrAddr[3:2].
- We  input  1  write strobe, qualified by device select upstream.
- DIn  input  DATA_W  write data, from PrDOut.
- DOut  output  DATA_W  read data, to PrDIn.
- IRQ  output  1  interrupt request, to HWInt bit.

Behaviour:
- Register map:
  - 0 CTRL (R/W): [0] EN, [2:1] MODE, [3] IM.
  - 1 PRESET (R/W).
  - 2 COUNT (read-only; writes ignored).
  - 3 reserved: reads 0, writes ignored.
- DOut is combinational on Addr, with no read latency. CTRL reads are zero-extended.
- Reset (rst=0, asynchronous, any state):
  - CTRL=0, PRESET=0, COUNT=0, state=IDLE, pending=0, IRQ=0.
  - Deasserting rst mid-count restarts from IDLE with all registers cleared.
- Writes: registered on posedge when We=1.
  - A write to CTRL always clears pending.
  - A PRESET write during CNT does not touch COUNT; it takes effect at the next LOAD.
- MODE encoding: 00 = one-shot. 01 = auto-reload. 1x is reserved and behaves as 00.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN=1 go to LOAD, else stay. COUNT is held.
  - LOAD: COUNT<=PRESET; go to CNT.
  - CNT:
    - If EN=0, go to IDLE with COUNT frozen.
    - Else if COUNT==0, go to INT.
    - Else COUNT<=COUNT-1.
  - INT: set pending. Then, by mode:
    - One-shot: clear EN, go to IDLE; pending stays set until a CTRL write.
    - Auto-reload: go to LOAD; pending clears on the following cycle, giving a one-cycle pulse.
- IRQ is registered and equals pending & IM. It asserts the cycle after INT is entered.
- Latency: write EN=1 at edge 0 with PRESET=P.
  - LOAD occurs at edge 1.
  - COUNT reaches 0 at edge 1+P.
  - INT is entered at edge 2+P.
  - IRQ is high after edge 3+P.
  - PRESET=0 gives INT at edge 2.
- Auto-reload period is P+3 cycles between IRQ pulses.
- Simultaneous events:
  - A CTRL write in the same cycle the FSM enters or sits in INT wins. Pending is cleared, and EN/MODE/IM take the written values.
  - The next state is then computed from the written EN: EN=0 goes to IDLE, EN=1 goes to LOAD.
  - Clearing EN while in LOAD or INT goes to IDLE on the next edge.
- COUNT never wraps: decrement only occurs when COUNT!=0. PRESET=2^DATA_W-1 is legal.
- IM=0 masks IRQ but not pending. Setting IM later exposes a still-pending one-shot interrupt only if no CTRL write cleared it. Because setting IM requires a CTRL write, a masked interrupt is effectively discarded. This is intentional.

Decomposition:
- Shared macro header gets:
  - register offsets: TIMER_CTRL, TIMER_PRESET, TIMER_COUNT;
  - CTRL bit positions: EN, MODE, IM;
  - mode codes;
  - FSM state encodings: TIMER_IDLE, TIMER_LOAD, TIMER_CNT, TIMER_INT.
- Single module; no sub-module. The counter and FSM are too tightly coupled to split.

Test Plan:
- Reset mid-count: PRESET=100, EN=1, pull rst low at COUNT=50 -> all reads 0, IRQ=0 immediately (async), FSM IDLE.
- One-shot: PRESET=5, CTRL=4'b1001 -> COUNT reads 5,4,3,2,1,0. IRQ rises after edge 8 and holds for 20+ cycles. Reading CTRL gives EN=0. Writing CTRL=0 drops IRQ next cycle.
- Auto-reload: PRESET=3, CTRL=4'b1011 -> IRQ one-cycle pulses every 6 cycles, 4 pulses observed. EN remains 1.
- Mask and freeze: CTRL=4'b0001, PRESET=2 -> IRQ stays 0. Separately, clear EN mid-count at COUNT=7 -> COUNT holds 7. Re-enabling reloads PRESET.
- Collision: CTRL write 4'b1011 landing in the INT cycle of a one-shot -> no IRQ pulse, FSM goes to LOAD, periodic operation follows.
- Edge values: PRESET=0 -> INT at edge 2. PRESET=32'hFFFFFFFF -> first decrement gives 32'hFFFFFFFE. Write to Addr 2 and 3 -> no effect; Addr 3 reads 0.

Source files
------------

// File: rtl/bus_timer_pkg.sv
// Shared definitions for the bus timer: register offsets, CTRL field positions,
// mode codes and FSM state encodings.
package bus_timer_pkg;

  localparam logic [1:0] TIMER_CTRL   = 2'd0;
  localparam logic [1:0] TIMER_PRESET = 2'd1;
  localparam logic [1:0] TIMER_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  // Mode codes 1x are reserved and fall through to one-shot behaviour.
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef enum logic [1:0] {
    TIMER_IDLE = 2'd0,
    TIMER_LOAD = 2'd1,
    TIMER_CNT  = 2'd2,
    TIMER_INT  = 2'd3
  } timer_state_e;

endpackage

// File: rtl/bus_timer_if.sv
// Processor-bus view of the timer: word address, write strobe, data both ways, IRQ.
interface bus_timer_if #(
  parameter int DATA_W = 32
);
  // No valid/ready: We is a one-cycle write strobe already qualified by the
  // upstream device select; reads are combinational on Addr with no strobe.
  logic [1:0]        Addr;
  logic              We;
  logic [DATA_W-1:0] DIn;
  logic [DATA_W-1:0] DOut;
  logic              IRQ;

  modport master (output Addr, output We, output DIn, input DOut, input IRQ);
  modport slave  (input Addr, input We, input DIn, output DOut, output IRQ);
endinterface

// File: rtl/bus_timer.sv
// Programmable down-counting timer with one-shot sticky and auto-reload pulse
// interrupt modes, exposed as three word registers on the processor bus.
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  bus_timer_if.slave  bus,
  output logic [1:0]  dbg_state
);

  timer_state_e      state_q, state_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d, ctrl_eff;
  logic [DATA_W-1:0] preset_q, preset_d;
  logic [DATA_W-1:0] count_q, count_d;
  logic              pending_q, pending_d;
  logic              irq_q, irq_d;
  logic              ctrl_wr, preset_wr, en_eff, reload_eff;

  assign ctrl_wr   = bus.We && (bus.Addr == TIMER_CTRL);
  assign preset_wr = bus.We && (bus.Addr == TIMER_PRESET);

  // A CTRL write in the same cycle overrides the stored fields, so the FSM
  // decides on the value being written rather than the stale one.
  assign ctrl_eff   = ctrl_wr ? bus.DIn[CTRL_W-1:0] : ctrl_q;
  assign en_eff     = ctrl_eff[CTRL_EN];
  assign reload_eff = (ctrl_eff[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    ctrl_d    = ctrl_eff;
    preset_d  = preset_wr ? bus.DIn : preset_q;
    pending_d = pending_q & ~ctrl_wr;
    case (state_q)
      TIMER_IDLE: begin
        if (en_eff) state_d = TIMER_LOAD;
      end
      TIMER_LOAD: begin
        if (reload_eff) pending_d = 1'b0;
        if (!en_eff) begin
          state_d = TIMER_IDLE;
        end else begin
          count_d = preset_q;
          state_d = TIMER_CNT;
        end
      end
      TIMER_CNT: begin
        if (!en_eff)                state_d = TIMER_IDLE;
        else if (count_q == '0)     state_d = TIMER_INT;
        else                        count_d = count_q - DATA_W'(1);
      end
      TIMER_INT: begin
        if (ctrl_wr) begin
          state_d = en_eff ? TIMER_LOAD : TIMER_IDLE;
        end else begin
          pending_d = 1'b1;
          if (reload_eff) begin
            state_d = TIMER_LOAD;
          end else begin
            ctrl_d[CTRL_EN] = 1'b0;
            state_d         = TIMER_IDLE;
          end
        end
      end
      default: state_d = TIMER_IDLE;
    endcase
    irq_d = pending_d & ctrl_d[CTRL_IM];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= TIMER_IDLE;
      ctrl_q    <= '0;
      preset_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
    end
  end

  always_comb begin
    bus.DOut = '0;
    case (bus.Addr)
      TIMER_CTRL:   bus.DOut[CTRL_W-1:0] = ctrl_q;
      TIMER_PRESET: bus.DOut = preset_q;
      TIMER_COUNT:  bus.DOut = count_q;
      default:      bus.DOut = '0;
    endcase
  end

  assign bus.IRQ   = irq_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: reset, one-shot, auto-reload, mask/freeze,
// CTRL/INT collision and edge values, with hand-computed expectations.
module tb_bus_timer;
  import bus_timer_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  dbg_state;
  int          checks;
  int          failures;
  logic [31:0] exp_q[$];

  bus_timer_if #(.DATA_W(32)) bif ();

  bus_timer #(.DATA_W(32), .CTRL_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bif.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks: callers sit at a negedge; writes register on the next posedge
  task automatic do_reset();
    rst      = 1'b0;
    bif.We   = 1'b0;
    bif.Addr = 2'd0;
    bif.DIn  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bif.Addr = a;
    bif.We   = 1'b1;
    bif.DIn  = d;
    @(negedge clk);
    bif.We   = 1'b0;
    bif.Addr = 2'd0;
    bif.DIn  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bif.Addr = a;
    #1;
    d = bif.DOut;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    bus_read(2'd0, d);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL reset_ctrl actual=%h expected=%h", d, 32'd0); end
    checks++;
    if (bif.IRQ !== 1'b0) begin failures++; $display("FAIL reset_irq actual=%b expected=0", bif.IRQ); end
    bus_write(TIMER_PRESET, 32'd100);
    bus_write(TIMER_CTRL, 32'h1);
    repeat (51) @(negedge clk);
    bus_read(TIMER_COUNT, d);
    checks++;
    if (d !== 32'd50) begin failures++; $display("FAIL mid_count actual=%0d expected=50", d); end
    #1 rst = 1'b0;
    #1;
    for (int a = 0; a < 4; a++) begin
      bus_read(a[1:0], d);
      checks++;
      if (d !== 32'd0) begin failures++; $display("FAIL async_reset_read addr=%0d actual=%h expected=0", a, d); end
    end
    checks++;
    if (bif.IRQ !== 1'b0) begin failures++; $display("FAIL async_reset_irq actual=%b expected=0", bif.IRQ); end
    checks++;
    if (dbg_state !== TIMER_IDLE) begin failures++; $display("FAIL async_reset_state actual=%0d expected=%0d", dbg_state, TIMER_IDLE); end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (dbg_state !== TIMER_IDLE) begin failures++; $display("FAIL post_reset_state actual=%0d expected=%0d", dbg_state, TIMER_IDLE); end
  endtask

  task automatic test_oneshot();
    logic [31:0] d;
    do_reset();
    bus_write(TIMER_PRESET, 32'd5);
    bus_write(TIMER_CTRL, 32'h9);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      bus_read(TIMER_COUNT, d);
      checks++;
      if (d !== 32'(6 - k)) begin failures++; $display("FAIL oneshot_count edge=%0d actual=%0d expected=%0d", k, d, 6 - k); end
    end
    @(negedge clk);
    checks++;
    if (bif.IRQ !== 1'b0) begin failures++; $display("FAIL oneshot_irq_early actual=%b expected=0", bif.IRQ); end
    checks++;
    if (dbg_state !== TIMER_INT) begin failures++; $display("FAIL oneshot_int_state actual=%0d expected=%0d", dbg_state, TIMER_INT); end
    for (int k = 8; k < 30; k++) begin
      @(negedge clk);
      checks++;
      if (bif.IRQ !== 1'b1) begin failures++; $display("FAIL oneshot_irq_hold edge=%0d actual=%b expected=1", k, bif.IRQ); end
    end
    bus_read(TIMER_CTRL, d);
    checks++;
    if (d !== 32'h8) begin failures++; $display("FAIL oneshot_ctrl_en_cleared actual=%h expected=%h", d, 32'h8); end
    bus_write(TIMER_CTRL, 32'h0);
    checks++;
    if (bif.IRQ !== 1'b0) begin failures++; $display("FAIL oneshot_irq_clear actual=%b expected=0", bif.IRQ); end
  endtask

  task automatic test_autoreload();
    logic [31:0] d;
    int          pulses;
    logic        exp_irq;
    do_reset();
    exp_q  = {32'd6, 32'd12, 32'd18, 32'd24};
    pulses = 0;
    bus_write(TIMER_PRESET, 32'd3);
    bus_write(TIMER_CTRL, 32'hB);
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      exp_irq = (exp_q.size() > 0) && (exp_q[0] == 32'(k));
      if (exp_irq) void'(exp_q.pop_front());
      if (bif.IRQ === 1'b1) pulses++;
      checks++;
      if (bif.IRQ !== exp_irq) begin failures++; $display("FAIL reload_irq edge=%0d actual=%b expected=%b", k, bif.IRQ, exp_irq); end
    end
    checks++;
    if (pulses != 4) begin failures++; $display("FAIL reload_pulse_count actual=%0d expected=4", pulses); end
    bus_read(TIMER_CTRL, d);
    checks++;
    if (d !== 32'hB) begin failures++; $display("FAIL reload_ctrl_en_kept actual=%h expected=%h", d, 32'hB); end
  endtask

  task automatic test_mask_freeze();
    logic [31:0] d;
    do_reset();
    bus_write(TIMER_PRESET, 32'd2);
    bus_write(TIMER_CTRL, 32'h1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      checks++;
      if (bif.IRQ !== 1'b0) begin failures++; $display("FAIL masked_irq edge=%0d actual=%b expected=0", k, bif.IRQ); end
    end
    bus_read(TIMER_CTRL, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL masked_ctrl actual=%h expected=0", d); end

    do_reset();
    bus_write(TIMER_PRESET, 32'd10);
    bus_write(TIMER_CTRL, 32'h1);
    repeat (4) @(negedge clk);
    bus_read(TIMER_COUNT, d);
    checks++;
    if (d !== 32'd7) begin failures++; $display("FAIL freeze_pre actual=%0d expected=7", d); end
    bus_write(TIMER_CTRL, 32'h0);
    repeat (3) @(negedge clk);
    bus_read(TIMER_COUNT, d);
    checks++;
    if (d !== 32'd7) begin failures++; $display("FAIL freeze_hold actual=%0d expected=7", d); end
    checks++;
    if (dbg_state !== TIMER_IDLE) begin failures++; $display("FAIL freeze_state actual=%0d expected=%0d", dbg_state, TIMER_IDLE); end
    bus_write(TIMER_CTRL, 32'h1);
    @(negedge clk);
    bus_read(TIMER_COUNT, d);
    checks++;
    if (d !== 32'd10) begin failures++; $display("FAIL reenable_reload actual=%0d expected=10", d); end
  endtask

  task automatic test_collision();
    logic exp_irq;
    do_reset();
    bus_write(TIMER_PRESET, 32'd2);
    bus_write(TIMER_CTRL, 32'h9);
    repeat (4) @(negedge clk);
    checks++;
    if (dbg_state !== TIMER_INT) begin failures++; $display("FAIL collide_in_int actual=%0d expected=%0d", dbg_state, TIMER_INT); end
    bus_write(TIMER_CTRL, 32'hB);
    checks++;
    if (dbg_state !== TIMER_LOAD) begin failures++; $display("FAIL collide_next_load actual=%0d expected=%0d", dbg_state, TIMER_LOAD); end
    checks++;
    if (bif.IRQ !== 1'b0) begin failures++; $display("FAIL collide_no_pulse actual=%b expected=0", bif.IRQ); end
    for (int k = 6; k <= 16; k++) begin
      @(negedge clk);
      exp_irq = (k == 10) || (k == 15);
      checks++;
      if (bif.IRQ !== exp_irq) begin failures++; $display("FAIL collide_periodic edge=%0d actual=%b expected=%b", k, bif.IRQ, exp_irq); end
    end
  endtask

  task automatic test_edges();
    logic [31:0] d;
    do_reset();
    bus_write(TIMER_CTRL, 32'h9);
    @(negedge clk);
    checks++;
    if (dbg_state !== TIMER_CNT) begin failures++; $display("FAIL zero_preset_cnt actual=%0d expected=%0d", dbg_state, TIMER_CNT); end
    @(negedge clk);
    checks++;
    if (dbg_state !== TIMER_INT) begin failures++; $display("FAIL zero_preset_int actual=%0d expected=%0d", dbg_state, TIMER_INT); end
    @(negedge clk);
    checks++;
    if (bif.IRQ !== 1'b1) begin failures++; $display("FAIL zero_preset_irq actual=%b expected=1", bif.IRQ); end

    do_reset();
    bus_write(TIMER_PRESET, 32'hFFFF_FFFF);
    bus_write(TIMER_CTRL, 32'h1);
    @(negedge clk);
    bus_read(TIMER_COUNT, d);
    checks++;
    if (d !== 32'hFFFF_FFFF) begin failures++; $display("FAIL max_load actual=%h expected=%h", d, 32'hFFFF_FFFF); end
    @(negedge clk);
    bus_read(TIMER_COUNT, d);
    checks++;
    if (d !== 32'hFFFF_FFFE) begin failures++; $display("FAIL max_first_dec actual=%h expected=%h", d, 32'hFFFF_FFFE); end

    do_reset();
    bus_write(TIMER_COUNT, 32'h55);
    bus_write(2'd3, 32'h66);
    for (int a = 0; a < 4; a++) begin
      bus_read(a[1:0], d);
      checks++;
      if (d !== 32'd0) begin failures++; $display("FAIL ignored_write addr=%0d actual=%h expected=0", a, d); end
    end
    checks++;
    if (dbg_state !== TIMER_IDLE) begin failures++; $display("FAIL ignored_write_state actual=%0d expected=%0d", dbg_state, TIMER_IDLE); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    bif.We   = 1'b0;
    bif.Addr = 2'd0;
    bif.DIn  = '0;
    @(negedge clk);
    test_reset();
    test_oneshot();
    test_autoreload();
    test_mask_freeze();
    test_collision();
    test_edges();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
